// File: rtl/instruction_cache_pkg.sv
// Shared types for the instruction cache: FSM state encoding and a saturating counter helper.
// The optional statistics counters are enabled with ICACHE_STATS_EN.
package instruction_cache_pkg;

    localparam int ICACHE_STATE_WIDTH = 2;

    typedef enum logic [ICACHE_STATE_WIDTH-1:0] {
        ST_IDLE = 2'd0,
        ST_MISS = 2'd1,
        ST_RESP = 2'd2
    } icache_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/instruction_cache_array.sv
// Direct-mapped storage: valid/tag/data/compressed per entry, combinational read,
// synchronous write, and asynchronous clear of the valid bits only.
module icache_array #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 11
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [31:0]            rd_data,
    output logic                   rd_comp,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [31:0]            wr_data,
    input  logic                   wr_comp
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     valid_d;
    logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
    logic [31:0]          data_q [DEPTH];
    logic                 comp_q [DEPTH];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
            comp_q[wr_idx] <= wr_comp;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];
    assign rd_comp  = comp_q[rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache between Decoder fetch and MemoryControl reads.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int ADDR_WIDTH  = 18
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush,
    input  logic          dec_en,
    input  logic [31:0]   dec_addr,
    output logic          dec_rdy,
    output logic [31:0]   dec_data,
    output logic          dec_is_compressed,
    output logic          mc_en,
    output logic [31:0]   mc_addr,
    input  logic          mc_rdy,
    input  logic [31:0]   mc_data,
    input  logic          mc_is_compressed,
`ifdef ICACHE_STATS_EN
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count,
`endif
    output icache_state_e dbg_state
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 1;

    // Handshake: dec_en/dec_addr are held until dec_rdy; dec_rdy and mc_rdy are
    // single-cycle strobes; mc_en stays high until the matching mc_rdy or a flush.
    icache_state_e state_q, state_d;
    logic          dec_rdy_q, dec_rdy_d;
    logic [31:0]   dec_data_q, dec_data_d;
    logic          dec_comp_q, dec_comp_d;
    logic          mc_en_q, mc_en_d;
    logic [31:0]   mc_addr_q, mc_addr_d;
`ifdef ICACHE_STATS_EN
    logic [31:0]   hit_cnt_q, hit_cnt_d;
    logic [31:0]   miss_cnt_q, miss_cnt_d;
`endif

    logic [INDEX_WIDTH-1:0] rd_idx;
    logic [TAG_WIDTH-1:0]   rd_tag_req;
    logic                   rd_valid;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [31:0]            rd_data;
    logic                   rd_comp;
    logic                   hit;
    logic                   wr_en;

    assign rd_idx     = dec_addr[INDEX_WIDTH:1];
    assign rd_tag_req = dec_addr[ADDR_WIDTH-1:INDEX_WIDTH+1];
    assign hit        = rd_valid && (rd_tag == rd_tag_req);

    // Fill is keyed by the latched miss address rather than the live request.
    icache_array #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_array (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_idx  (rd_idx),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .rd_comp (rd_comp),
        .wr_en   (wr_en),
        .wr_idx  (mc_addr_q[INDEX_WIDTH:1]),
        .wr_tag  (mc_addr_q[ADDR_WIDTH-1:INDEX_WIDTH+1]),
        .wr_data (mc_data),
        .wr_comp (mc_is_compressed)
    );

    always_comb begin
        state_d    = state_q;
        dec_rdy_d  = dec_rdy_q;
        dec_data_d = dec_data_q;
        dec_comp_d = dec_comp_q;
        mc_en_d    = mc_en_q;
        mc_addr_d  = mc_addr_q;
        wr_en      = 1'b0;
`ifdef ICACHE_STATS_EN
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
`endif
        if (rdy_in) begin
            if (flush) begin
                state_d   = ST_IDLE;
                dec_rdy_d = 1'b0;
                mc_en_d   = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (dec_en) begin
                            if (hit) begin
                                dec_data_d = rd_data;
                                dec_comp_d = rd_comp;
                                dec_rdy_d  = 1'b1;
                                state_d    = ST_RESP;
`ifdef ICACHE_STATS_EN
                                hit_cnt_d  = sat_inc(hit_cnt_q);
`endif
                            end else begin
                                mc_en_d    = 1'b1;
                                mc_addr_d  = dec_addr;
                                state_d    = ST_MISS;
`ifdef ICACHE_STATS_EN
                                miss_cnt_d = sat_inc(miss_cnt_q);
`endif
                            end
                        end
                    end
                    ST_MISS: begin
                        if (mc_rdy) begin
                            wr_en      = 1'b1;
                            dec_data_d = mc_data;
                            dec_comp_d = mc_is_compressed;
                            dec_rdy_d  = 1'b1;
                            mc_en_d    = 1'b0;
                            state_d    = ST_RESP;
                        end
                    end
                    ST_RESP: begin
                        dec_rdy_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            dec_rdy_q  <= 1'b0;
            dec_data_q <= '0;
            dec_comp_q <= 1'b0;
            mc_en_q    <= 1'b0;
            mc_addr_q  <= '0;
`ifdef ICACHE_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dec_rdy_q  <= dec_rdy_d;
            dec_data_q <= dec_data_d;
            dec_comp_q <= dec_comp_d;
            mc_en_q    <= mc_en_d;
            mc_addr_q  <= mc_addr_d;
`ifdef ICACHE_STATS_EN
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`endif
        end
    end

    assign dec_rdy           = dec_rdy_q;
    assign dec_data          = dec_data_q;
    assign dec_is_compressed = dec_comp_q;
    assign mc_en             = mc_en_q;
    assign mc_addr           = mc_addr_q;
    assign dbg_state         = state_q;
`ifdef ICACHE_STATS_EN
    assign hit_count         = hit_cnt_q;
    assign miss_count        = miss_cnt_q;
`endif

    // Address bits outside the cached range are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dec_addr[31:ADDR_WIDTH], dec_addr[0],
                                mc_addr_q[31:ADDR_WIDTH], mc_addr_q[0]};

endmodule

// File: tb/tb_instruction_cache.sv
// Directed testbench for instruction_cache with a response scoreboard.
// Counter checks are compiled in when ICACHE_STATS_EN is defined.
module tb_instruction_cache;
    import instruction_cache_pkg::*;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          flush = 1'b0;
    logic          dec_en = 1'b0;
    logic [31:0]   dec_addr = '0;
    logic          dec_rdy;
    logic [31:0]   dec_data;
    logic          dec_is_compressed;
    logic          mc_en;
    logic [31:0]   mc_addr;
    logic          mc_rdy = 1'b0;
    logic [31:0]   mc_data = '0;
    logic          mc_is_compressed = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif
    icache_state_e dbg_state;

    int n_checks = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [32:0] exp_q[$];

    instruction_cache dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .flush            (flush),
        .dec_en           (dec_en),
        .dec_addr         (dec_addr),
        .dec_rdy          (dec_rdy),
        .dec_data         (dec_data),
        .dec_is_compressed(dec_is_compressed),
        .mc_en            (mc_en),
        .mc_addr          (mc_addr),
        .mc_rdy           (mc_rdy),
        .mc_data          (mc_data),
        .mc_is_compressed (mc_is_compressed),
`ifdef ICACHE_STATS_EN
        .hit_count        (hit_count),
        .miss_count       (miss_count),
`endif
        .dbg_state        (dbg_state)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef ICACHE_STATS_EN
        check({tag, "_hits"}, {32'b0, hit_count}, exp_hits);
        check({tag, "_misses"}, {32'b0, miss_count}, exp_misses);
`endif
    endtask

    task automatic pop_and_compare(input string tag);
        logic [32:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {31'b0, dec_is_compressed, dec_data}, {31'b0, exp});
        end
    endtask

    // Called at a negedge with the DUT idle; completes one Decoder fetch.
    task automatic fetch(input logic [31:0] addr, input bit exp_hit,
                         input logic [31:0] w, input logic c);
        int lat;
        dec_en = 1'b1;
        dec_addr = addr;
        exp_q.push_back({c, w});
        if (exp_hit) exp_hits++; else exp_misses++;
        @(negedge clk_in);
        check("hit_rdy", {63'b0, dec_rdy}, {63'b0, exp_hit});
        check("miss_req", {63'b0, mc_en}, {63'b0, !exp_hit});
        if (mc_en) begin
            check("mc_addr", {32'b0, mc_addr}, {32'b0, addr});
            lat = $urandom_range(0, 3);
            for (int i = 0; i < lat; i++) begin
                @(negedge clk_in);
                check("mc_hold", {62'b0, mc_en, dec_rdy}, 64'b10);
            end
            mc_rdy = 1'b1;
            mc_data = w;
            mc_is_compressed = c;
            @(negedge clk_in);
            mc_rdy = 1'b0;
            mc_data = $urandom;
            mc_is_compressed = 1'b0;
        end
        check("resp_rdy", {63'b0, dec_rdy}, 64'd1);
        if (dec_rdy) pop_and_compare("resp_data");
        else void'(exp_q.pop_front());
        check("resp_mc_en", {63'b0, mc_en}, 64'd0);
        dec_en = 1'b0;
        dec_addr = $urandom;
        @(negedge clk_in);
        check("rdy_drop", {63'b0, dec_rdy}, 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_dec_rdy", {63'b0, dec_rdy}, 64'd0);
        check("rst_mc_en", {63'b0, mc_en}, 64'd0);
        check("rst_dec_data", {32'b0, dec_data}, 64'd0);
        check("rst_mc_addr", {32'b0, mc_addr}, 64'd0);
        check("rst_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});
        check_counters("rst");
        rst_in = 1'b1;
        @(negedge clk_in);

        // Cold miss then hit at 0x0000
        fetch(32'h0000_0000, 1'b0, 32'h0000_0013, 1'b0);
        check_counters("cold");
        fetch(32'h0000_0000, 1'b1, 32'h0000_0013, 1'b0);
        check_counters("rehit");

        // Alias conflict at index 1, ignored high/low address bits
        fetch(32'h0000_0002, 1'b0, 32'h0000_4501, 1'b1);
        fetch(32'h0000_0002, 1'b1, 32'h0000_4501, 1'b1);
        fetch(32'h0000_0082, 1'b0, 32'hCAFE_0082, 1'b0);
        fetch(32'h0000_0002, 1'b0, 32'h0000_4501, 1'b1);
        fetch(32'h0004_0002, 1'b1, 32'h0000_4501, 1'b1);
        fetch(32'h0000_0001, 1'b1, 32'h0000_0013, 1'b0);
        check_counters("alias");

        // Flush in MISS with a coincident mc_rdy
        dec_en = 1'b1;
        dec_addr = 32'h0000_0100;
        exp_misses++;
        @(negedge clk_in);
        check("flush_mc_en", {63'b0, mc_en}, 64'd1);
        flush = 1'b1;
        mc_rdy = 1'b1;
        mc_data = 32'h1111_2222;
        @(negedge clk_in);
        flush = 1'b0;
        mc_rdy = 1'b0;
        dec_en = 1'b0;
        check("flush_no_rdy", {63'b0, dec_rdy}, 64'd0);
        check("flush_mc_drop", {63'b0, mc_en}, 64'd0);
        check("flush_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});
        @(negedge clk_in);
        check("flush_quiet", {63'b0, dec_rdy}, 64'd0);
        fetch(32'h0000_0100, 1'b0, 32'h3333_4444, 1'b0);
        check_counters("flush");

        // Freeze during RESP; flush while frozen must be ignored
        dec_en = 1'b1;
        dec_addr = 32'h0000_0100;
        exp_hits++;
        exp_q.push_back({1'b0, 32'h3333_4444});
        @(negedge clk_in);
        check("frz_rdy", {63'b0, dec_rdy}, 64'd1);
        pop_and_compare("frz_data");
        rdy_in = 1'b0;
        dec_en = 1'b0;
        flush = 1'b1;
        mc_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("frz_hold", {63'b0, dec_rdy}, 64'd1);
            check("frz_state", {62'b0, dbg_state}, {62'b0, ST_RESP});
        end
        flush = 1'b0;
        mc_rdy = 1'b0;
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("frz_drop", {63'b0, dec_rdy}, 64'd0);
        @(negedge clk_in);
        check("frz_stay_low", {63'b0, dec_rdy}, 64'd0);
        check_counters("freeze");

        // Asynchronous reset mid-MISS
        dec_en = 1'b1;
        dec_addr = 32'h0000_0200;
        @(negedge clk_in);
        check("arst_pre_mc_en", {63'b0, mc_en}, 64'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_mc_en", {63'b0, mc_en}, 64'd0);
        check("arst_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});
        dec_en = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        check_counters("arst");
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        fetch(32'h0000_0000, 1'b0, 32'h0000_0013, 1'b0);
        fetch(32'h0000_0002, 1'b0, 32'h0000_4501, 1'b1);
        fetch(32'h0000_0100, 1'b0, 32'h3333_4444, 1'b0);
        fetch(32'h0000_0002, 1'b1, 32'h0000_4501, 1'b1);
        check_counters("post_rst");

        check("queue_empty", exp_q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
